// File: rtl/kmkz_irq_timer.sv
// kmkz_irq_timer: 32-line interrupt collector (level or rising-edge per line)
// plus a reloading down-counter that emits a one-cycle tick every PERIOD+1
// cycles. Pending & enabled lines and the tick feed the exception unit.
module kmkz_irq_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] irq_i,
  input  logic        bus_sel_i,
  input  logic        bus_we_i,
  input  logic [2:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic [31:0] exp_irq_o,
  output logic        exp_tick_o
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_PERIOD  = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;

  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] sync;
  logic [31:0] sync_d;
  logic [31:0] pending;
  logic [31:0] enable;
  logic [31:0] edge_mode;
  logic [31:0] period;
  logic [31:0] count;
  logic        run;

  logic        wr;
  logic        rd;
  logic [31:0] w1c_mask;
  logic [31:0] rise;
  logic [31:0] pending_nxt;
  logic [31:0] rd_mux;
  logic        advance;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign wr        = bus_sel_i & bus_we_i;
  assign rd        = bus_sel_i & ~bus_we_i;
  assign w1c_mask  = (wr && bus_addr_i == ADDR_PENDING) ? bus_wdata_i : 32'h0;
  assign rise      = sync & ~sync_d;
  assign advance   = run && (period != 32'h0);
  assign exp_irq_o = pending & enable;

  // Edge lines: a new edge beats a same-cycle W1C; level lines just follow sync.
  assign pending_nxt = (edge_mode & (rise | (pending & ~w1c_mask)))
                     | (~edge_mode & sync);

  // Metastability chain for the asynchronous lines, plus the edge-detect delay.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 32'h0;
      sync_d <= 32'h0;
    end else begin
      sync_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d <= sync;
    end
  end

  // Interrupt registers: pending update every cycle, RW mask/mode registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending   <= 32'h0;
      enable    <= 32'h0;
      edge_mode <= 32'h0;
    end else begin
      pending <= pending_nxt;
      if (wr && bus_addr_i == ADDR_ENABLE) enable    <= bus_wdata_i;
      if (wr && bus_addr_i == ADDR_EDGE)   edge_mode <= bus_wdata_i;
    end
  end

  // Timer: a PERIOD write reloads COUNT outright; otherwise count down and
  // reload with a tick on reaching zero, only while running with PERIOD != 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      period     <= 32'h0;
      count      <= 32'h0;
      run        <= 1'b0;
      exp_tick_o <= 1'b0;
    end else begin
      exp_tick_o <= 1'b0;
      if (wr && bus_addr_i == ADDR_CTRL) run <= bus_wdata_i[0];
      if (wr && bus_addr_i == ADDR_PERIOD) begin
        period <= bus_wdata_i;
        count  <= bus_wdata_i;
      end else if (advance) begin
        if (count == 32'h0) begin
          count      <= period;
          exp_tick_o <= 1'b1;
        end else begin
          count <= count - 32'd1;
        end
      end
    end
  end

  // Read data selection for the addressed register.
  always_comb begin
    rd_mux = 32'h0;
    case (bus_addr_i)
      ADDR_PENDING: rd_mux = pending;
      ADDR_ENABLE:  rd_mux = enable;
      ADDR_EDGE:    rd_mux = edge_mode;
      ADDR_PERIOD:  rd_mux = period;
      ADDR_COUNT:   rd_mux = count;
      ADDR_CTRL:    rd_mux = {31'h0, run};
      default:      rd_mux = 32'h0;
    endcase
  end

  // Registered read port; holds the last read value between reads.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) bus_rdata_o <= 32'h0;
    else if (rd) bus_rdata_o <= rd_mux;
  end

endmodule

// File: tb/tb_kmkz_irq_timer.sv
// Bench for kmkz_irq_timer: random and directed stimulus checked against a
// cycle-counting model of the interrupt latency and timer period.
module tb_kmkz_irq_timer;
  logic        clk;
  logic        rst;
  logic [31:0] irq;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] exp_irq;
  logic        exp_tick;

  int checks = 0;
  int errors = 0;

  kmkz_irq_timer #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq),
    .bus_sel_i(bus_sel), .bus_we_i(bus_we), .bus_addr_i(bus_addr),
    .bus_wdata_i(bus_wdata), .bus_rdata_o(bus_rdata),
    .exp_irq_o(exp_irq), .exp_tick_o(exp_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end at posedge+1.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    step();
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  task automatic pulse(input logic [31:0] v);
    irq = v; step(); irq = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    repeat (3) step();
    checks++; if (exp_irq !== 32'h0) begin errors++; $display("FAIL reset_irq got %h want 0", exp_irq); end
    checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", exp_tick); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_rdata); end
    rst = 1'b1;
    step();
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
    end
  endtask

  // Level lines: exp_irq equals the input three cycles earlier, masked by ENABLE;
  // random W1C writes must have no effect.
  task automatic test_level();
    logic [31:0] q[$];
    logic [31:0] en, v;
    en = $urandom | 32'h1;
    bus_write(3'd1, en);
    bus_write(3'd2, 32'h0);
    repeat (4) step();
    q = '{32'h0, 32'h0, 32'h0};
    for (int n = 0; n < 40; n++) begin
      checks++;
      if (exp_irq !== (q[0] & en)) begin
        errors++; $display("FAIL level_irq step %0d got %h want %h", n, exp_irq, q[0] & en);
      end
      void'(q.pop_front());
      v = $urandom;
      irq = v; q.push_back(v);
      bus_sel = 1'($urandom_range(0, 1)); bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = $urandom;
      step();
    end
    bus_sel = 1'b0; irq = 32'h0;
    repeat (5) step();
  endtask

  // Edge lines: a bit sets on a rising synchronised edge and clears only by W1C,
  // with a coinciding edge winning.
  task automatic test_edge();
    logic [31:0] q[$];
    logic [31:0] pend, prev_w1c, rise, v, w;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'hFFFF_FFFF);
    q = '{32'h0, 32'h0, 32'h0, 32'h0};
    pend = 32'h0; prev_w1c = 32'hFFFF_FFFF;
    for (int n = 0; n < 60; n++) begin
      rise = q[1] & ~q[0];
      pend = rise | (pend & ~prev_w1c);
      checks++;
      if (exp_irq !== pend) begin
        errors++; $display("FAIL edge_irq step %0d got %h want %h", n, exp_irq, pend);
      end
      void'(q.pop_front());
      v = $urandom & $urandom & $urandom;
      irq = v; q.push_back(v);
      w = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = w;
      prev_w1c = w;
      step();
    end
    bus_sel = 1'b0; bus_we = 1'b0; irq = 32'h0;
    repeat (6) step();
    bus_write(3'd0, 32'hFFFF_FFFF);
    step();
    checks++; if (exp_irq !== 32'h0) begin errors++; $display("FAIL edge_cleanup got %h want 0", exp_irq); end
  endtask

  task automatic test_edge_bit5();
    logic [31:0] d;
    pulse(32'h20);
    repeat (4) step();
    checks++; if (exp_irq !== 32'h20) begin errors++; $display("FAIL edge5_set got %h want 20", exp_irq); end
    repeat (5) step();
    checks++; if (exp_irq !== 32'h20) begin errors++; $display("FAIL edge5_hold got %h want 20", exp_irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL edge5_read got %h want 20", d); end
    bus_write(3'd0, 32'h20);
    bus_read(3'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge5_cleared got %h want 0", d); end
    checks++; if (exp_irq !== 32'h0) begin errors++; $display("FAIL edge5_irq_cleared got %h want 0", exp_irq); end
    // W1C lands on the same edge that captures the rising edge.
    pulse(32'h20);
    step();
    bus_write(3'd0, 32'h20);
    checks++; if (exp_irq !== 32'h20) begin errors++; $display("FAIL collide_irq got %h want 20", exp_irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL collide_read got %h want 20", d); end
    bus_write(3'd0, 32'h20);
  endtask

  task automatic test_enable_and_mode();
    logic [31:0] d;
    bus_write(3'd1, 32'h0);
    pulse(32'h200);
    repeat (5) step();
    checks++; if (exp_irq !== 32'h0) begin errors++; $display("FAIL masked_irq got %h want 0", exp_irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h200) begin errors++; $display("FAIL masked_pending got %h want 200", d); end
    bus_write(3'd1, 32'h200);
    checks++; if (exp_irq !== 32'h200) begin errors++; $display("FAIL unmask_irq got %h want 200", exp_irq); end
    // Switching the line to level keeps it pending until the next level load.
    bus_write(3'd2, ~32'h200);
    checks++; if (exp_irq !== 32'h200) begin errors++; $display("FAIL mode_keep got %h want 200", exp_irq); end
    step();
    checks++; if (exp_irq !== 32'h0) begin errors++; $display("FAIL mode_level_load got %h want 0", exp_irq); end
    bus_write(3'd2, 32'h0);
    bus_write(3'd1, 32'h0);
  endtask

  // Timer: after loading, COUNT follows P - (a mod (P+1)) where a counts
  // advancing cycles, and a tick follows every (P+1)th advance.
  task automatic test_timer();
    int unsigned p, a;
    logic [31:0] exp_rd;
    logic exp_t, prev_tick;
    for (int k = 0; k < 4; k++) begin
      p = (k == 0) ? 3 : $urandom_range(1, 7);
      bus_write(3'd3, p);
      bus_write(3'd5, 32'h1);
      a = 0; prev_tick = 1'b0;
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 3'd4;
      for (int n = 0; n < 3 * (p + 1) + 2; n++) begin
        step();
        a++;
        exp_rd = p - ((a - 1) % (p + 1));
        exp_t = ((a % (p + 1)) == 0);
        checks++;
        if (bus_rdata !== exp_rd) begin errors++; $display("FAIL timer_count p=%0d a=%0d got %0d want %0d", p, a, bus_rdata, exp_rd); end
        checks++;
        if (exp_tick !== exp_t) begin errors++; $display("FAIL timer_tick p=%0d a=%0d got %b want %b", p, a, exp_tick, exp_t); end
        if (exp_tick && prev_tick) begin checks++; errors++; $display("FAIL timer_double_tick p=%0d got 1 want 0", p); end
        prev_tick = exp_tick;
      end
      bus_sel = 1'b0;
      bus_write(3'd5, 32'h0);
    end
  endtask

  task automatic test_freeze_and_priority();
    logic [31:0] d;
    int ticks;
    bus_write(3'd3, 32'd3);
    bus_write(3'd5, 32'h1);
    bus_write(3'd5, 32'h0);
    ticks = 0;
    for (int n = 0; n < 10; n++) begin step(); if (exp_tick) ticks++; end
    checks++; if (ticks != 0) begin errors++; $display("FAIL freeze_ticks got %0d want 0", ticks); end
    bus_read(3'd4, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL freeze_count got %0d want 2", d); end
    bus_write(3'd5, 32'h1);
    step();
    checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL resume_t1 got %b want 0", exp_tick); end
    step();
    checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL resume_t2 got %b want 0", exp_tick); end
    step();
    checks++; if (exp_tick !== 1'b1) begin errors++; $display("FAIL resume_t3 got %b want 1", exp_tick); end
    bus_write(3'd5, 32'h0);
    // PERIOD write on the cycle COUNT hits zero: load wins, no tick.
    bus_write(3'd3, 32'd2);
    bus_write(3'd5, 32'h1);
    step(); step();
    bus_write(3'd3, 32'd5);
    checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL period_write_tick got %b want 0", exp_tick); end
    bus_read(3'd4, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL period_write_count got %0d want 5", d); end
    bus_write(3'd5, 32'h0);
    // PERIOD = 0 holds the counter idle.
    bus_write(3'd3, 32'd0);
    bus_write(3'd5, 32'h1);
    ticks = 0;
    for (int n = 0; n < 100; n++) begin step(); if (exp_tick) ticks++; end
    checks++; if (ticks != 0) begin errors++; $display("FAIL period0_ticks got %0d want 0", ticks); end
    bus_read(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL period0_count got %0d want 0", d); end
    bus_write(3'd5, 32'h0);
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    irq = 32'h4;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'd3);
    bus_write(3'd5, 32'h1);
    step(); step();
    checks++; if (exp_irq !== 32'h4) begin errors++; $display("FAIL prereset_irq got %h want 4", exp_irq); end
    #1 rst = 1'b0;
    #1;
    checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b want 0", exp_tick); end
    checks++; if (exp_irq !== 32'h0) begin errors++; $display("FAIL midrst_irq got %h want 0", exp_irq); end
    irq = 32'h0;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL inrst_tick cyc %0d got %b want 0", n, exp_tick); end
    end
    rst = 1'b1;
    repeat (4) step();
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL postrst_reg%0d got %h want 0", a, d); end
    end
    checks++; if (exp_tick !== 1'b0) begin errors++; $display("FAIL postrst_tick got %b want 0", exp_tick); end
  endtask

  initial begin
    rst = 1'b0; irq = 32'h0;
    bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 32'h0;
    #1;
    test_reset();
    test_level();
    test_edge();
    test_edge_bit5();
    test_enable_and_mode();
    test_timer();
    test_freeze_and_priority();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kmkz_irq_timer.md
KMKZ_IRQ_TIMER -- requirements
Module: kmkz_irq_timer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of flip-flop stages in the irq_i synchroniser (legal 2..4).
REQ-002 The block SHALL have the following ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-low.
- irq_i  in  32  external interrupt lines; asynchronous, active-high.
- bus_sel_i  in  1  register access strobe, one cycle per access.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_i  in  3  word index of the register.
- bus_wdata_i  in  32  write data.
- bus_rdata_o  out  32  read data, registered.
- exp_irq_o  out  32  pending & enabled vector; feeds exp_irq_i of the exception unit.
- exp_tick_o  out  1  one-cycle timer pulse; feeds exp_tick_i of the exception unit.

Function
REQ-003 Each irq_i bit SHALL pass through SYNC_STAGES flip-flops; the last stage is sync[n], and a further register holds sync_d[n].
REQ-004 Registers by bus_addr_i SHALL be:
- 0 PENDING: RW1C.
- 1 ENABLE: RW.
- 2 EDGE: RW; 1 = rising-edge, 0 = level.
- 3 PERIOD: RW.
- 4 COUNT: RO.
- 5 CTRL: bit0 = timer run, other bits read 0.
- 6-7: read 0, writes ignored.
REQ-005 For a level line (EDGE[n]=0), PENDING[n] SHALL be loaded with sync[n] every cycle, and W1C on that bit SHALL have no effect.
REQ-006 For an edge line (EDGE[n]=1), PENDING[n] SHALL set on a cycle where sync[n]=1 and sync_d[n]=0, and SHALL clear only on a PENDING write with bus_wdata_i[n]=1.
REQ-007 If an edge set and a W1C fall on the same bit in the same cycle, set SHALL win.
REQ-008 exp_irq_o SHALL equal PENDING & ENABLE combinationally from registers, with no masking by EDGE.
REQ-009 Latency from the irq_i rising edge sampled at clock k to PENDING/exp_irq_o high SHALL be SYNC_STAGES+1 cycles, for both level and edge lines.
REQ-010 Changing EDGE[n] SHALL NOT clear PENDING[n]; a subsequent level update applies normally.
REQ-011 A read SHALL present data on bus_rdata_o in the cycle after bus_sel_i, and bus_rdata_o SHALL hold its value until the next read.
REQ-012 A write SHALL take effect at the clock edge where bus_sel_i=1 and bus_we_i=1.
REQ-013 Timer: COUNT is a 32-bit down-counter and SHALL advance only while CTRL[0]=1 and PERIOD!=0.
REQ-014 When COUNT=0 and the timer is advancing, the block SHALL reload COUNT<=PERIOD and drive exp_tick_o=1 for exactly that cycle; otherwise it SHALL decrement COUNT.
REQ-015 The tick period SHALL therefore be PERIOD+1 cycles.
REQ-016 A write to PERIOD SHALL also load COUNT with the written value, and this SHALL take priority over decrement and reload in that cycle, with no tick.
REQ-017 Clearing CTRL[0] SHALL freeze COUNT, and exp_tick_o SHALL be 0.
REQ-018 Setting CTRL[0] SHALL resume counting from the frozen COUNT.
REQ-019 PERIOD=0 SHALL hold COUNT and generate no ticks.
REQ-020 exp_tick_o SHALL be registered, and SHALL never be high on two consecutive cycles unless PERIOD=0... excluded per REQ-019; i.e. exp_tick_o SHALL never be high on two consecutive cycles.

Reset
REQ-021 On rst_i=0 the block SHALL asynchronously clear all synchroniser stages, sync_d, PENDING, ENABLE, EDGE, PERIOD, COUNT, CTRL, bus_rdata_o and exp_tick_o to 0; exp_irq_o is then 0.
REQ-022 Reset asserted mid-count or mid-access SHALL abort the access and the count with no tick emitted.
REQ-023 After rst_i deassertion, irq_i already high SHALL be seen as a rising edge (sync_d=0).

Verification
REQ-024 Level line, SYNC_STAGES=2: ENABLE=1, EDGE=0, irq_i[0] high at cycle k -> exp_irq_o=0x1 from k+3; irq_i[0] low -> 0 three cycles later.
REQ-025 Edge line: EDGE[5]=1, ENABLE[5]=1, 1-cycle-wide synchronous pulse on irq_i[5] -> exp_irq_o=0x20 held until PENDING write 0x20; read PENDING returns 0x20 then 0x0.
REQ-026 Edge set and W1C in the same cycle on bit 5 -> PENDING[5] stays 1.
REQ-027 PERIOD=3, CTRL=1 -> exp_tick_o pulses every 4 cycles; COUNT reads 3,2,1,0 sequence.
REQ-028 CTRL=0 at COUNT=2 -> COUNT stays 2, no tick.
REQ-029 PERIOD=0 -> no ticks over 100 cycles.
REQ-030 rst_i low while COUNT=1 -> all registers 0 and no tick.
REQ-031 ENABLE=0 with an edge captured -> PENDING=1, exp_irq_o=0; ENABLE=1 -> exp_irq_o set the same cycle.
